// File: rtl/sbox_sched.sv
// rtl/sbox_sched.sv - shares LANES AES sbox lanes between SubBytes and SubWord requesters
// Optional SBOX_SCHED_RR_EN: round-robin tie arbitration instead of key-first priority.

module sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Multiplicative inverse as x^254; x = 0 naturally maps to 0.
    always_comb begin
        sq  = din;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module sbox_sched #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    output logic [127:0] st_out,
    output logic         st_done,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [31:0]  key_in,
    output logic [31:0]  key_out,
    output logic         key_done,
    output logic         busy
);
    localparam int NCH = 16 / LANES;

    typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KEY, DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   cnt;
    logic [127:0] op_reg;
    logic         op_key;
    logic [127:0] st_nxt;
    logic         st_acc;
    logic         key_acc;
    logic         key_wins;
    logic         st_wins;
    logic [7:0]   lane_in  [LANES];
    logic [7:0]   lane_out [LANES];

`ifdef SBOX_SCHED_RR_EN
    logic last_key;
    assign key_wins = !last_key;
    assign st_wins  = last_key;
`else
    assign key_wins = 1'b1;
    assign st_wins  = !key_valid;
`endif

    assign key_ready = !rst && (state == IDLE) && (!st_valid || key_wins);
    assign st_ready  = !rst && (state == IDLE) && (!key_valid || st_wins);
    assign key_acc   = key_valid && key_ready;
    assign st_acc    = st_valid && st_ready;
    assign st_done   = !rst && (state == DONE) && !op_key;
    assign key_done  = !rst && (state == DONE) && op_key;
    assign busy      = (state != IDLE);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox u_sbox (.din(lane_in[g]), .dout(lane_out[g]));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_acc) state_nxt = RUN_KEY;
                     else if (st_acc) state_nxt = RUN_ST;
            RUN_ST:  if (cnt == 2'(NCH - 1)) state_nxt = DONE;
            RUN_KEY: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Key words sit in the top 32 bits of op_reg so lanes 0..3 read bytes 0..3.
    always_comb begin
        st_nxt = st_out;
        for (int j = 0; j < LANES; j++) begin
            lane_in[j] = 8'h00;
            if (state == RUN_ST) begin
                lane_in[j] = op_reg[127 - 8 * (int'(cnt) * LANES + j) -: 8];
                st_nxt[127 - 8 * (int'(cnt) * LANES + j) -: 8] = lane_out[j];
            end else if (state == RUN_KEY && j < 4) begin
                lane_in[j] = op_reg[127 - 8 * j -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            op_reg  <= '0;
            op_key  <= 1'b0;
            st_out  <= '0;
            key_out <= '0;
`ifdef SBOX_SCHED_RR_EN
            last_key <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (key_acc) begin
                        op_reg <= {key_in, 96'h0};
                        op_key <= 1'b1;
                        cnt    <= 2'd0;
`ifdef SBOX_SCHED_RR_EN
                        last_key <= 1'b1;
`endif
                    end else if (st_acc) begin
                        op_reg <= st_in;
                        op_key <= 1'b0;
                        cnt    <= 2'd0;
`ifdef SBOX_SCHED_RR_EN
                        last_key <= 1'b0;
`endif
                    end
                end
                RUN_ST: begin
                    st_out <= st_nxt;
                    cnt    <= cnt + 2'd1;
                end
                RUN_KEY: key_out <= {lane_out[0], lane_out[1], lane_out[2], lane_out[3]};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_sched.sv
// tb/tb_sbox_sched.sv - scoreboard bench for sbox_sched (LANES=4 and LANES=16 instances)

module tb_sbox_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic st_valid, st_ready, st_done, key_valid, key_ready, key_done, busy;
    logic [127:0] st_in, st_out;
    logic [31:0] key_in, key_out;

    logic st_valid_b, st_ready_b, st_done_b, key_valid_b, key_ready_b, key_done_b, busy_b;
    logic [127:0] st_in_b, st_out_b;
    logic [31:0] key_in_b, key_out_b;

    sbox_sched #(.LANES(4)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in), .st_out(st_out), .st_done(st_done),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .key_out(key_out),
        .key_done(key_done), .busy(busy)
    );

    sbox_sched #(.LANES(16)) dut_b (
        .clk(clk), .rst(rst),
        .st_valid(st_valid_b), .st_ready(st_ready_b), .st_in(st_in_b), .st_out(st_out_b),
        .st_done(st_done_b),
        .key_valid(key_valid_b), .key_ready(key_ready_b), .key_in(key_in_b), .key_out(key_out_b),
        .key_done(key_done_b), .busy(busy_b)
    );

    typedef struct {
        logic [127:0] val;
        int           cyc;
    } exp_t;

    exp_t stq[$];
    exp_t keyq[$];
    exp_t stqb[$];
    exp_t keyqb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [127:0] hold_st = '0;
    logic [127:0] hold_key = '0;

    localparam logic [127:0] S1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E1  = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] S2  = {4{32'h00010203}};
    localparam logic [127:0] E2  = {4{32'h637c777b}};
    localparam logic [31:0]  K1  = 32'h00010203;
    localparam logic [31:0]  EK1 = 32'h637c777b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_st(input logic [127:0] d, input logic [127:0] e, input bit push, output int acc);
        bit got;
        got = 0;
        acc = -1;
        @(negedge clk);
        st_valid = 1'b1;
        st_in    = d;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (st_ready) begin got = 1; acc = cyc; break; end
            @(negedge clk);
        end
        chk("st_accept", 128'(got), 128'(1));
        if (got && push) stq.push_back('{e, acc + 5});
        @(negedge clk);
        st_valid = 1'b0;
        st_in    = ~d;
    endtask

    task automatic do_key(input logic [31:0] d, input logic [31:0] e, output int acc);
        bit got;
        got = 0;
        acc = -1;
        @(negedge clk);
        key_valid = 1'b1;
        key_in    = d;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (key_ready) begin got = 1; acc = cyc; break; end
            @(negedge clk);
        end
        chk("key_accept", 128'(got), 128'(1));
        if (got) keyq.push_back('{{96'h0, e}, acc + 2});
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = ~d;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (st_done) begin
            if (stq.size() == 0) chk("st_done_unexpected", 128'(st_done), 128'(0));
            else begin
                e = stq.pop_front();
                chk("st_out", st_out, e.val);
                chk("st_done_cycle", 128'(cyc), 128'(e.cyc));
                chk("st_op_keeps_key_out", {96'h0, key_out}, hold_key);
                hold_st = e.val;
            end
        end
        if (key_done) begin
            if (keyq.size() == 0) chk("key_done_unexpected", 128'(key_done), 128'(0));
            else begin
                e = keyq.pop_front();
                chk("key_out", {96'h0, key_out}, e.val);
                chk("key_done_cycle", 128'(cyc), 128'(e.cyc));
                chk("key_op_keeps_st_out", st_out, hold_st);
                hold_key = e.val;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (st_done_b) begin
            if (stqb.size() == 0) chk("b_st_done_unexpected", 128'(st_done_b), 128'(0));
            else begin
                e = stqb.pop_front();
                chk("b_st_out", st_out_b, e.val);
                chk("b_st_done_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
        if (key_done_b) begin
            if (keyqb.size() == 0) chk("b_key_done_unexpected", 128'(key_done_b), 128'(0));
            else begin
                e = keyqb.pop_front();
                chk("b_key_out", {96'h0, key_out_b}, e.val);
                chk("b_key_done_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    initial begin
        int acc;
        int n;
        int kacc;
        bit got;
        bit grants [3];
        bit exp_g  [3];

        rst = 1'b1;
        st_valid = 1'b1; key_valid = 1'b1; st_in = S1; key_in = K1;
        st_valid_b = 1'b0; key_valid_b = 1'b0; st_in_b = '0; key_in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_st_ready", 128'(st_ready), 128'(0));
        chk("rst_key_ready", 128'(key_ready), 128'(0));
        chk("rst_st_out", st_out, 128'h0);
        chk("rst_key_out", 128'(key_out), 128'h0);
        chk("rst_dones", 128'({st_done, key_done}), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        #1;
        chk("rel_key_ready", 128'(key_ready), 128'(1));
        chk("rel_st_ready", 128'(st_ready), 128'(0));
        st_valid = 1'b0; key_valid = 1'b0;

        do_st(S1, E1, 1, acc);
        repeat (8) @(negedge clk);
        do_key(K1, EK1, acc);
        repeat (5) @(negedge clk);
        do_st('0, {16{8'h63}}, 1, acc);
        repeat (8) @(negedge clk);

        // Both requesters held pending across three grants.
`ifdef SBOX_SCHED_RR_EN
        exp_g[0] = 1; exp_g[1] = 0; exp_g[2] = 1;
`else
        exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1;
`endif
        @(negedge clk);
        st_valid = 1'b1; key_valid = 1'b1; st_in = S2; key_in = K1;
        n = 0;
        for (int t = 0; t < 60 && n < 3; t++) begin
            #1;
            if (key_ready) begin
                grants[n] = 1; n++;
                keyq.push_back('{{96'h0, EK1}, cyc + 2});
            end else if (st_ready) begin
                grants[n] = 0; n++;
                stq.push_back('{E2, cyc + 5});
            end
            if (n < 3) @(negedge clk);
        end
        chk("tie_grant_count", 128'(n), 128'(3));
        @(negedge clk);
        st_valid = 1'b0; key_valid = 1'b0;
        for (int i = 0; i < 3; i++) chk($sformatf("tie_grant_%0d_is_key", i), 128'(grants[i]), 128'(exp_g[i]));
        repeat (10) @(negedge clk);

        do_st(S1, E1, 0, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_st = '0;
        hold_key = '0;
        #1;
        chk("abort_st_out", st_out, 128'h0);
        chk("abort_key_out", 128'(key_out), 128'h0);
        chk("abort_busy", 128'(busy), 128'(0));
        repeat (6) @(negedge clk);
        do_st(S1, E1, 1, acc);
        repeat (8) @(negedge clk);

        @(negedge clk);
        st_valid_b = 1'b1;
        st_in_b = {16{8'h53}};
        #1;
        chk("b_st_ready", 128'(st_ready_b), 128'(1));
        acc = cyc;
        stqb.push_back('{{16{8'hed}}, acc + 2});
        @(negedge clk);
        st_valid_b = 1'b0;
        st_in_b = '0;
        key_valid_b = 1'b1;
        key_in_b = K1;
        got = 0;
        kacc = -1;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (key_ready_b) begin got = 1; kacc = cyc; break; end
            @(negedge clk);
        end
        chk("b_key_accept", 128'(got), 128'(1));
        chk("b_back_to_back_accept_cycle", 128'(kacc), 128'(acc + 3));
        if (got) keyqb.push_back('{{96'h0, EK1}, kacc + 2});
        @(negedge clk);
        key_valid_b = 1'b0;
        repeat (6) @(negedge clk);

        chk("st_queue_drained", 128'(stq.size()), 128'(0));
        chk("key_queue_drained", 128'(keyq.size()), 128'(0));
        chk("b_queues_drained", 128'(stqb.size() + keyqb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
